// File: rtl/loader_pkg.sv
// Shared types for the program loader: FSM state encoding and the default frame sync marker.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/loader_word_packer.sv
// Big-endian byte-to-word packer: shifts bytes in MSB-first and emits a one-cycle word_valid
// with the completed word, which is then held until the next word completes.
module loader_word_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              clr,
  input  logic              i_clear,
  input  logic              i_shift,
  input  logic [7:0]        i_byte,
  output logic              o_last_byte,
  output logic              o_word_valid,
  output logic [DATA_W-1:0] o_word
);

  localparam int BYTES  = DATA_W / 8;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_word;
  logic [BCNT_W-1:0] r_cnt;
  logic              r_valid;
  logic [DATA_W-1:0] w_next;

  assign w_next       = (r_shift << 8) | DATA_W'(i_byte);
  assign o_last_byte  = (r_cnt == BCNT_W'(BYTES - 1));
  assign o_word_valid = r_valid;
  assign o_word       = r_word;

  always_ff @(posedge clk_in or posedge clr) begin
    if (clr) begin
      r_shift <= '0;
      r_word  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_clear) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (i_shift) begin
        r_shift <= w_next;
        if (o_last_byte) begin
          r_cnt   <= '0;
          r_word  <= w_next;
          r_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + BCNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream program loader: SYNC, LEN, data words, optional XOR checksum
// (enabled by defining LOADER_CHECKSUM_EN). Holds the CPU in reset while loading.
module program_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W         = 8,
  parameter int         DATA_W         = 32,
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk_in,
  input  logic              clr,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              prog_write,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int CNT_W = ((ADDR_W > 8) ? ADDR_W : 8) + 1;

  state_t            r_state;
  logic              r_byte_ready, r_busy, r_cpu_hold, r_load_done, r_load_err, r_last;
  logic [ADDR_W-1:0] r_index, r_prog_addr;
  logic [CNT_W-1:0]  r_words_left;
  logic [TMO_W-1:0]  r_tmo;
  logic [7:0]        r_chk;
  logic              w_accept, w_start, w_shift, w_in_frame, w_timeout, w_word_done;
  logic              w_last_byte, w_word_valid;
  logic [DATA_W-1:0] w_word;

  assign w_accept    = byte_valid & r_byte_ready;
  assign w_start     = (r_state == S_IDLE) && w_accept && (byte_data == SYNC_BYTE);
  assign w_shift     = (r_state == S_DATA) && !r_last && w_accept;
  assign w_word_done = w_shift & w_last_byte;
  assign w_in_frame  = (r_state == S_LEN) || (r_state == S_CHECK) ||
                       ((r_state == S_DATA) && !r_last);
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && w_in_frame && !w_accept &&
                       (32'(r_tmo) == TIMEOUT_CYCLES - 1);

  loader_word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk_in      (clk_in),
    .clr         (clr),
    .i_clear     (w_start),
    .i_shift     (w_shift),
    .i_byte      (byte_data),
    .o_last_byte (w_last_byte),
    .o_word_valid(w_word_valid),
    .o_word      (w_word)
  );

  assign byte_ready = r_byte_ready;
  assign prog_write = w_word_valid;
  assign prog_data  = w_word;
  assign prog_addr  = r_prog_addr;
  assign cpu_hold   = r_cpu_hold;
  assign busy       = r_busy;
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;

  // Idle-gap counter between bytes; only meaningful inside a frame.
  always_ff @(posedge clk_in or posedge clr) begin
    if (clr)           r_tmo <= '0;
    else if (w_accept) r_tmo <= '0;
    else if (w_in_frame) r_tmo <= r_tmo + TMO_W'(1);
  end

  always_ff @(posedge clk_in or posedge clr) begin
    if (clr) begin
      r_state      <= S_IDLE;
      r_byte_ready <= 1'b1;
      r_busy       <= 1'b0;
      r_cpu_hold   <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_last       <= 1'b0;
      r_index      <= '0;
      r_prog_addr  <= '0;
      r_words_left <= '0;
      r_chk        <= '0;
    end else begin
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      if (w_word_done) begin
        r_prog_addr  <= r_index;
        r_index      <= r_index + ADDR_W'(1);
        r_words_left <= r_words_left - CNT_W'(1);
      end
      if (w_shift) r_chk <= r_chk ^ byte_data;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_state    <= S_LEN;
          r_busy     <= 1'b1;
          r_cpu_hold <= 1'b1;
        end
        S_LEN: if (w_timeout) begin
          r_state      <= S_ERR;
          r_byte_ready <= 1'b0;
          r_load_err   <= 1'b1;
        end else if (w_accept) begin
          r_words_left <= (byte_data == 8'h00) ? (CNT_W'(1) << ADDR_W) : CNT_W'(byte_data);
          r_index      <= '0;
          r_chk        <= byte_data;
          r_last       <= 1'b0;
          r_state      <= S_DATA;
        end
        S_DATA: if (r_last) begin
          // Final write strobe is on the bus this cycle; the frame is complete.
          r_last       <= 1'b0;
          r_state      <= S_DONE;
          r_byte_ready <= 1'b0;
          r_load_done  <= 1'b1;
          r_cpu_hold   <= 1'b0;
        end else if (w_timeout) begin
          r_state      <= S_ERR;
          r_byte_ready <= 1'b0;
          r_load_err   <= 1'b1;
        end else if (w_word_done && r_words_left == CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
          r_state <= S_CHECK;
`else
          r_last  <= 1'b1;
`endif
        end
        S_CHECK: if (w_timeout || (w_accept && byte_data != r_chk)) begin
          r_state      <= S_ERR;
          r_byte_ready <= 1'b0;
          r_load_err   <= 1'b1;
        end else if (w_accept) begin
          r_state      <= S_DONE;
          r_byte_ready <= 1'b0;
          r_load_done  <= 1'b1;
          r_cpu_hold   <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_byte_ready <= 1'b1;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: random frames, timeout, clr mid-frame, checksum
// (when LOADER_CHECKSUM_EN is defined).
module tb_program_loader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;

  logic              clk, clr;
  logic [7:0]        byte_data;
  logic              byte_valid, byte_ready, prog_write, cpu_hold, busy, load_done, load_err;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;

  program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk), .clr(clr), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .prog_write(prog_write), .prog_addr(prog_addr),
    .prog_data(prog_data), .cpu_hold(cpu_hold), .busy(busy),
    .load_done(load_done), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         wr_q[$];
  logic [7:0]  ev_q[$];
  logic [31:0] fw[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe / completion pulse must match the next expected item.
  always @(negedge clk) begin
    if (!clr) begin
      if (prog_write) begin
        if (wr_q.size() == 0) chk("unexpected_write", {24'h0, prog_addr, prog_data}, 64'h0);
        else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("wr_addr", 64'(prog_addr), 64'(e.a));
          chk("wr_data", 64'(prog_data), 64'(e.d));
        end
      end
      if (load_done || load_err) begin
        logic [7:0] got;
        got = load_done ? "D" : "E";
        if (ev_q.size() == 0) chk("unexpected_event", 64'(got), 64'h0);
        else chk("event_kind", 64'(got), 64'(ev_q.pop_front()));
        chk("ready_in_end", 64'(byte_ready), 64'h0);
        chk("hold_in_end", 64'(cpu_hold), load_done ? 64'h0 : 64'h1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_wait", 64'(byte_ready), 64'h1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic send_frame(input bit bad_chk);
    int          n;
    logic [7:0]  len, sum, b;
    n   = fw.size();
    len = n[7:0];
    sum = len;
    for (int i = 0; i < n; i++) wr_q.push_back('{a: i[7:0], d: fw[i]});
`ifdef LOADER_CHECKSUM_EN
    ev_q.push_back(bad_chk ? "E" : "D");
`else
    ev_q.push_back("D");
`endif
    send_byte(8'hA5);
    chk("hold_after_sync", 64'(cpu_hold), 64'h1);
    chk("busy_after_sync", 64'(busy), 64'h1);
    gap();
    send_byte(len);
    for (int i = 0; i < n; i++) begin
      for (int k = 3; k >= 0; k--) begin
        gap();
        b = fw[i][8*k +: 8];
        sum ^= b;
        send_byte(b);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    gap();
    send_byte(sum ^ {7'h0, bad_chk});
`endif
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((wr_q.size() != 0 || ev_q.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", 64'(wr_q.size() + ev_q.size()), 64'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic load_test1();
    fw.delete();
    fw.push_back(32'h12345678);
    fw.push_back(32'hDEADBEEF);
  endtask

  task automatic junk(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      do b = 8'($urandom_range(0, 255)); while (b == 8'hA5);
      send_byte(b);
    end
  endtask

  initial begin
    int n_err;
    clr = 1'b1; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(byte_ready), 64'h1);
    chk("rst_write", 64'(prog_write), 64'h0);
    chk("rst_addr", 64'(prog_addr), 64'h0);
    chk("rst_data", 64'(prog_data), 64'h0);
    chk("rst_hold", 64'(cpu_hold), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done_err", {62'h0, load_done, load_err}, 64'h0);
    clr = 1'b0;
    @(negedge clk);

    // Basic two-word frame, then again behind leading garbage bytes.
    load_test1(); send_frame(1'b0); drain();
    chk("t1_hold", 64'(cpu_hold), 64'h0);
    chk("t1_busy", 64'(busy), 64'h0);
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
    load_test1(); send_frame(1'b0); drain();

    // LEN=0: full 256-word frame, then a short frame restarting at address 0.
    fw.delete();
    for (int i = 0; i < 256; i++) fw.push_back($urandom);
    send_frame(1'b0); drain();
    fw.delete(); fw.push_back($urandom); send_frame(1'b0); drain();

    // Inter-byte timeout with a partial word pending.
    ev_q.push_back("E");
    send_byte(8'hA5); gap(); send_byte(8'h01); gap(); send_byte(8'hAA); gap(); send_byte(8'hBB);
    n_err = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (load_err && n_err == 0) n_err = n;
    end
    chk("timeout_cycles", 64'(n_err), 64'(TMO));
    drain();
    chk("tmo_busy", 64'(busy), 64'h0);
    chk("tmo_hold", 64'(cpu_hold), 64'h1);

`ifdef LOADER_CHECKSUM_EN
    load_test1(); send_frame(1'b1); drain();
    chk("badchk_hold", 64'(cpu_hold), 64'h1);
`endif
    load_test1(); send_frame(1'b0); drain();
    chk("recover_hold", 64'(cpu_hold), 64'h0);

    // clr in the middle of a word.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    clr = 1'b1;
    #1;
    chk("clr_ready", 64'(byte_ready), 64'h1);
    chk("clr_outs", {prog_write, cpu_hold, busy, load_done, load_err}, 64'h0);
    chk("clr_addr_data", {prog_addr, prog_data}, 64'h0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    load_test1(); send_frame(1'b0); drain();

    // Random frames with random leading garbage.
    for (int f = 0; f < 20; f++) begin
      junk($urandom_range(0, 3));
      fw.delete();
      for (int i = 0, n = $urandom_range(1, 8); i < n; i++) fw.push_back($urandom);
      send_frame(1'b0);
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
